uart_rx_fifo: RTL and testbench

Parametrised UART receiver for the serial-link datapath.
- Configurable frame: 5–9 data bits, optional even/odd parity, 1 or 2 stop bits.
- 2-flop input synchroniser and 3-sample majority voting per bit.
- Per-word parity and framing status, plus break and overrun detection.
- Received words are buffered in a small FIFO and drained over a valid/ready interface.

---
 rtl/uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop synchroniser, 3-sample majority vote, parity/framing/break
// detection and an output FIFO drained over valid/ready.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rx,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              overrun,
    output logic                              break_det,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT = BIT_TIME / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_TIME);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W    = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    logic                 r_sync1;
    logic                 r_rs;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_err;
    logic                 r_all_zero;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_overrun;
    logic                 r_break;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_stop_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_perr_nxt;
    logic                 w_zero_nxt;
    logic                 w_push_c;
    logic                 w_ferr_c;
    logic                 w_brk_c;
    logic                 w_bit_end;
    logic                 w_bit_c;

    logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [FCNT_W-1:0]    r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr_en;
    logic [ENT_W-1:0]     w_entry;
    logic [ENT_W-1:0]     w_head;

    // Two-flop synchroniser; resets high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rs    <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rs    <= r_sync1;
        end
    end

    // First two of the three vote samples; the third is rs itself at the decision cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_cnt == CNT_W'(BIT_TIME - 3)) r_s0 <= r_rs;
            if (r_cnt == CNT_W'(BIT_TIME - 2)) r_s1 <= r_rs;
        end
    end

    assign w_bit_end = (r_cnt == CNT_W'(BIT_TIME - 1));
    assign w_bit_c   = (r_s0 & r_s1) | (r_s0 & r_rs) | (r_s1 & r_rs);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_par_err  <= 1'b0;
            r_all_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_idx <= w_stop_nxt;
            r_data     <= w_data_nxt;
            r_par_err  <= w_perr_nxt;
            r_all_zero <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_stop_nxt  = r_stop_idx;
        w_data_nxt  = r_data;
        w_perr_nxt  = r_par_err;
        w_zero_nxt  = r_all_zero;
        w_push_c    = 1'b0;
        w_ferr_c    = 1'b0;
        w_brk_c     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_W'(HALF_BIT - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_rs) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                        w_zero_nxt  = 1'b1;
                        w_perr_nxt  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt  = '0;
                    w_data_nxt = {w_bit_c, r_data[DATA_BITS-1:1]};
                    w_zero_nxt = r_all_zero & ~w_bit_c;
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = ((^r_data) ^ w_bit_c) != 1'(PARITY == 2);
                    w_zero_nxt  = r_all_zero & ~w_bit_c;
                    w_state_nxt = S_STOP;
                    w_stop_nxt  = 1'b0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (!w_bit_c) begin
                        // An all-zero frame through the first stop bit is a break, not a word.
                        if (r_all_zero && !r_stop_idx) begin
                            w_brk_c     = 1'b1;
                            w_state_nxt = S_BRK;
                        end else begin
                            w_push_c    = 1'b1;
                            w_ferr_c    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_push_c    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
            end
            S_BRK: begin
                w_cnt_nxt = '0;
                if (r_rs) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_full  = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_pop   = rx_valid & rx_ready;
    assign w_wr_en = w_push_c & (~w_full | w_pop);
    assign w_entry = {w_ferr_c, r_par_err, r_data};

    // FIFO storage; a full FIFO still accepts a push when the head leaves in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overrun <= w_push_c & w_full & ~w_pop;
            r_break   <= w_brk_c;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rx_data    = w_head[DATA_BITS-1:0];
    assign parity_err = w_head[DATA_BITS];
    assign frame_err  = w_head[DATA_BITS+1];
    assign rx_valid   = (r_count != '0);
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign break_det  = r_break;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 instance and a 7E1 instance driven with hand-built frames.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx8, rx7;
    logic       rdy8, rdy7;
    logic [7:0] rx_data8;
    logic [6:0] rx_data7;
    logic       rx_valid8, rx_valid7;
    logic       parity_err8, parity_err7;
    logic       frame_err8, frame_err7;
    logic       overrun8, overrun7;
    logic       break_det8, break_det7;
    logic [2:0] fifo_count8, fifo_count7;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [9:0] log8 [0:31];
    int         n8 = 0, pcyc8 = 0, nbrk8 = 0, novr8 = 0;
    logic [8:0] last7 = '0;
    int         n7 = 0, pcyc7 = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) u8 (
        .clk(clk), .reset(reset), .rx(rx8), .rx_data(rx_data8), .rx_valid(rx_valid8),
        .rx_ready(rdy8), .parity_err(parity_err8), .frame_err(frame_err8),
        .overrun(overrun8), .break_det(break_det8), .fifo_count(fifo_count8));

    uart_rx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1)) u7 (
        .clk(clk), .reset(reset), .rx(rx7), .rx_data(rx_data7), .rx_valid(rx_valid7),
        .rx_ready(rdy7), .parity_err(parity_err7), .frame_err(frame_err7),
        .overrun(overrun7), .break_det(break_det7), .fifo_count(fifo_count7));

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted word and every status pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid8 && rdy8) begin
                log8[n8 % 32] <= {frame_err8, parity_err8, rx_data8};
                n8            <= n8 + 1;
                pcyc8         <= cyc;
            end
            if (rx_valid7 && rdy7) begin
                last7 <= {frame_err7, parity_err7, rx_data7};
                n7    <= n7 + 1;
                pcyc7 <= cyc;
            end
            if (break_det8) nbrk8 <= nbrk8 + 1;
            if (overrun8)   novr8 <= novr8 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame, 10 clocks per bit; spike_j inverts one cycle late in that bit.
    task automatic send(input bit sel, input logic [8:0] d, input int nb, input bit hp,
                        input logic pb, input logic sv, input int spike_j, output int s);
        logic [15:0] f;
        int          nf;
        logic        v;
        f  = '0;
        nf = nb + (hp ? 3 : 2);
        for (int i = 0; i < nb; i++) f[1+i] = d[i];
        if (hp) f[1+nb] = pb;
        f[nf-1] = sv;
        s = 0;
        for (int j = 0; j < nf; j++) begin
            for (int c = 0; c < 10; c++) begin
                v = f[j];
                if (j == spike_j && c == 5) v = ~v;
                if (sel) rx7 = v; else rx8 = v;
                if (j == 0 && c == 0) s = cyc;
                step(1);
            end
        end
        if (sel) rx7 = 1'b1; else rx8 = 1'b1;
    endtask

    initial begin
        int s, n0, b0;
        reset = 1'b1;
        rx8 = 1'b1; rx7 = 1'b1;
        rdy8 = 1'b1; rdy7 = 1'b1;
        step(3);
        chk("rst_valid", rx_valid8, 1'b0);
        chk("rst_count", fifo_count8, 3'd0);
        chk("rst_data", rx_data8, 8'h00);
        chk("rst_ovr_brk", {overrun8, break_det8, parity_err8, frame_err8}, 4'h0);
        reset = 1'b0;
        step(20);

        // 8N1 basic word and push latency
        n0 = n8;
        send(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, -1, s);
        step(20);
        chk("t1_npop", n8 - n0, 1);
        chk("t1_latency", pcyc8 - s, 98);
        chk("t1_word", log8[n0 % 32], {2'b00, 8'hA5});

        // 7E1 correct and wrong parity
        n0 = n7;
        send(1'b1, 9'h035, 7, 1'b1, 1'b0, 1'b1, -1, s);
        step(20);
        chk("t2_npop", n7 - n0, 1);
        chk("t2_latency", pcyc7 - s, 98);
        chk("t2_good_par", last7, {2'b00, 7'h35});
        send(1'b1, 9'h035, 7, 1'b1, 1'b1, 1'b1, -1, s);
        step(20);
        chk("t2_npop2", n7 - n0, 2);
        chk("t2_bad_par", last7, {2'b01, 7'h35});

        // framing error, then a short glitch, then a normal word
        n0 = n8;
        send(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, -1, s);
        step(30);
        chk("t3_npop", n8 - n0, 1);
        chk("t3_frame_err", log8[n0 % 32], {2'b10, 8'h3C});
        n0 = n8;
        rx8 = 1'b0;
        step(3);
        rx8 = 1'b1;
        step(30);
        chk("t3_glitch_npop", n8 - n0, 0);
        chk("t3_glitch_count", fifo_count8, 3'd0);
        send(1'b0, 9'h06B, 8, 1'b0, 1'b0, 1'b1, -1, s);
        step(20);
        chk("t3_after_glitch", log8[n0 % 32], {2'b00, 8'h6B});

        // break
        n0 = n8;
        b0 = nbrk8;
        rx8 = 1'b0;
        step(250);
        chk("t4_count_in_brk", fifo_count8, 3'd0);
        rx8 = 1'b1;
        step(30);
        chk("t4_brk_pulses", nbrk8 - b0, 1);
        chk("t4_npop", n8 - n0, 0);
        send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, -1, s);
        step(20);
        chk("t4_after_brk", log8[n0 % 32], {2'b00, 8'h11});

        // overrun with the consumer stalled, then drain in order
        rdy8 = 1'b0;
        b0 = novr8;
        for (int k = 1; k <= 5; k++) begin
            send(1'b0, 9'(k), 8, 1'b0, 1'b0, 1'b1, -1, s);
            step(10);
        end
        chk("t5_count_full", fifo_count8, 3'd4);
        chk("t5_ovr_pulses", novr8 - b0, 1);
        chk("t5_head", rx_data8, 8'h01);
        n0 = n8;
        rdy8 = 1'b1;
        step(10);
        chk("t5_ndrain", n8 - n0, 4);
        for (int k = 0; k < 4; k++) chk("t5_drain", log8[(n0 + k) % 32], 10'(k + 1));
        chk("t5_count_empty", fifo_count8, 3'd0);

        // reset mid-frame with a word waiting in the FIFO
        rdy8 = 1'b0;
        send(1'b0, 9'h077, 8, 1'b0, 1'b0, 1'b1, -1, s);
        step(10);
        chk("t6_pre_count", fifo_count8, 3'd1);
        n0 = n8;
        rx8 = 1'b0; step(10);
        rx8 = 1'b1; step(10);
        rx8 = 1'b0; step(10);
        rx8 = 1'b1; step(10);
        rx8 = 1'b0; step(5);
        reset = 1'b1;
        rx8 = 1'b1;
        #1;
        chk("t6_rst_valid", rx_valid8, 1'b0);
        chk("t6_rst_count", fifo_count8, 3'd0);
        chk("t6_rst_data", rx_data8, 8'h00);
        chk("t6_rst_flags", {overrun8, break_det8, parity_err8, frame_err8}, 4'h0);
        step(3);
        reset = 1'b0;
        rdy8 = 1'b1;
        step(30);
        chk("t6_no_push", n8 - n0, 0);
        send(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, -1, s);
        step(20);
        chk("t6_after_rst", log8[n0 % 32], {2'b00, 8'h5A});
        send(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 2, s);
        step(20);
        chk("t6_spike_npop", n8 - n0, 2);
        chk("t6_spike_word", log8[(n0 + 1) % 32], {2'b00, 8'hC3});
        send(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 7, s);
        step(20);
        chk("t6_spike_word2", log8[(n0 + 2) % 32], {2'b00, 8'hC3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
